// File: rtl/ff_stream_host.sv
// ff_stream_host: streams an N x D1 matrix into a feed-forward engine,
// launches it, waits for done (with timeout) and streams the result out.
module ff_stream_host #(
    parameter int N       = 3,
    parameter int D1      = 3,
    parameter int WIDTH   = 8,
    parameter int OWIDTH  = 24,
    parameter int TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_data,
    output logic [N*D1*WIDTH-1:0]     a_flat,
    output logic                      start,
    input  logic                      done,
    input  logic [N*D1*OWIDTH-1:0]    result_flat,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OWIDTH-1:0]         out_data,
    output logic                      out_last,
    output logic                      busy,
    output logic                      err_timeout
);

    localparam int NE = N * D1;
    localparam int IW = (NE > 1) ? $clog2(NE) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] LAST = IW'(NE - 1);
    localparam logic [CW-1:0] TLIM = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_FIRE,
        ST_WAIT,
        ST_DRAIN
    } state_t;

    state_t                   state_q, state_d;
    logic [IW-1:0]            idx_q, idx_d;
    logic [CW-1:0]            wcnt_q, wcnt_d;
    logic [NE*WIDTH-1:0]      a_q, a_d;
    logic [NE*OWIDTH-1:0]     buf_q, buf_d;
    logic                     err_q, err_d;

    // State register; reset abandons any load, wait or drain in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: index, wait counter, matrix, result buffer, error.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q  <= '0;
            wcnt_q <= '0;
            a_q    <= '0;
            buf_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            wcnt_q <= wcnt_d;
            a_q    <= a_d;
            buf_q  <= buf_d;
            err_q  <= err_d;
        end
    end

    // Next-state and handshake outputs; done only matters while waiting.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        wcnt_d    = wcnt_q;
        a_d       = a_q;
        buf_d     = buf_q;
        err_d     = err_q;
        in_ready  = 1'b0;
        start     = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        busy      = 1'b1;
        unique case (state_q)
            ST_LOAD: begin
                busy     = 1'b0;
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d[int'(idx_q)*WIDTH +: WIDTH] = in_data;
                    if (idx_q == LAST) begin
                        idx_d   = '0;
                        state_d = ST_FIRE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_FIRE: begin
                start   = 1'b1;
                wcnt_d  = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (done) begin
                    buf_d   = result_flat;
                    idx_d   = '0;
                    wcnt_d  = '0;
                    state_d = ST_DRAIN;
                end else if (wcnt_q == TLIM) begin
                    err_d   = 1'b1;
                    idx_d   = '0;
                    wcnt_d  = '0;
                    state_d = ST_LOAD;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                out_valid = 1'b1;
                out_data  = buf_q[int'(idx_q)*OWIDTH +: OWIDTH];
                out_last  = (idx_q == LAST);
                if (out_ready) begin
                    if (idx_q == LAST) begin
                        idx_d   = '0;
                        state_d = ST_LOAD;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    assign a_flat      = a_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_ff_stream_host.sv
// tb_ff_stream_host: directed vectors with hand-computed expectations
// for load, fire, wait, drain, stall, timeout and reset behaviour.
module tb_ff_stream_host;

    localparam int N  = 3;
    localparam int D1 = 3;
    localparam int W  = 8;
    localparam int OW = 24;
    localparam int TO = 16;
    localparam int NE = N * D1;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      in_data;
    logic [NE*W-1:0]   a_flat;
    logic              start;
    logic              done;
    logic [NE*OW-1:0]  result_flat;
    logic              out_valid;
    logic              out_ready;
    logic [OW-1:0]     out_data;
    logic              out_last;
    logic              busy;
    logic              err_timeout;

    int n_chk  = 0;
    int n_pass = 0;

    ff_stream_host #(
        .N(N), .D1(D1), .WIDTH(W), .OWIDTH(OW), .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .a_flat(a_flat),
        .start(start),
        .done(done),
        .result_flat(result_flat),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_last(out_last),
        .busy(busy),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] act,
                       input logic [255:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NE*W-1:0] mk_a(input int base);
        logic [NE*W-1:0] v;
        v = '0;
        for (int k = 0; k < NE; k++) begin
            v[k*W +: W] = W'(base + k);
        end
        return v;
    endfunction

    function automatic logic [NE*OW-1:0] mk_res(input int mul);
        logic [NE*OW-1:0] v;
        v = '0;
        for (int k = 0; k < NE; k++) begin
            v[k*OW +: OW] = OW'(mul * (k + 1));
        end
        return v;
    endfunction

    task automatic load_part(input int base, input int from, input int cnt);
        for (int k = from; k < from + cnt; k++) begin
            in_valid = 1'b1;
            in_data  = W'(base + k);
            chk("in_ready_load", in_ready, 1'b1);
            chk("start_load", start, 1'b0);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic fire_done(input logic [NE*OW-1:0] res);
        chk("start_fire", start, 1'b1);
        chk("in_ready_fire", in_ready, 1'b0);
        chk("busy_fire", busy, 1'b1);
        tick();
        chk("start_wait", start, 1'b0);
        chk("out_valid_wait", out_valid, 1'b0);
        result_flat = res;
        done        = 1'b1;
        tick();
        done        = 1'b0;
    endtask

    task automatic drain(input logic [NE*OW-1:0] res, input int stall_at,
                         input logic [NE*W-1:0] a_exp);
        logic [OW-1:0] e;
        out_ready = 1'b1;
        for (int k = 0; k < NE; k++) begin
            e = res[k*OW +: OW];
            if (k == stall_at) begin
                out_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    chk("stall_valid", out_valid, 1'b1);
                    chk("stall_data", out_data, e);
                    chk("stall_last", out_last, 1'b0);
                    tick();
                end
                out_ready = 1'b1;
            end
            chk("drain_valid", out_valid, 1'b1);
            chk("drain_data", out_data, e);
            chk("drain_last", out_last, (k == NE - 1));
            chk("drain_in_ready", in_ready, 1'b0);
            tick();
        end
        chk("a_flat_hold", a_flat, a_exp);
        chk("post_in_ready", in_ready, 1'b1);
        chk("post_out_valid", out_valid, 1'b0);
        chk("post_busy", busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        done        = 1'b0;
        result_flat = '0;
        out_ready   = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err_timeout, 1'b0);
        chk("rst_a_flat", a_flat, '0);
        chk("rst_start", start, 1'b0);
        chk("rst_out_data", out_data, '0);
        chk("rst_out_last", out_last, 1'b0);

        // Back-to-back load of 1..9, then straight drain.
        load_part(1, 0, NE);
        chk("a_elem_1_2", a_flat[5*W +: W], 8'd6);
        chk("a_full", a_flat, mk_a(1));
        fire_done(mk_res(10));
        drain(mk_res(10), -1, mk_a(1));

        // Downstream stall while 40 is presented.
        load_part(101, 0, NE);
        fire_done(mk_res(10));
        drain(mk_res(10), 3, mk_a(101));

        // No done: timeout after 16 WAIT cycles, back to LOAD.
        load_part(1, 0, NE);
        chk("start_to", start, 1'b1);
        tick();
        for (int c = 0; c < TO; c++) begin
            chk("to_busy", busy, 1'b1);
            chk("to_err_low", err_timeout, 1'b0);
            chk("to_out_valid", out_valid, 1'b0);
            chk("to_in_ready", in_ready, 1'b0);
            tick();
        end
        chk("to_err_set", err_timeout, 1'b1);
        chk("to_in_ready_back", in_ready, 1'b1);
        chk("to_out_valid_back", out_valid, 1'b0);
        chk("to_busy_back", busy, 1'b0);

        // Normal operation continues with the sticky flag set.
        load_part(11, 0, NE);
        fire_done(mk_res(-1000));
        drain(mk_res(-1000), -1, mk_a(11));
        chk("err_sticky", err_timeout, 1'b1);

        // done during LOAD after 4 elements is ignored.
        load_part(21, 0, 4);
        result_flat = mk_res(7);
        done        = 1'b1;
        tick();
        done        = 1'b0;
        chk("ign_in_ready", in_ready, 1'b1);
        chk("ign_out_valid", out_valid, 1'b0);
        chk("ign_busy", busy, 1'b0);
        tick();
        chk("ign_out_valid2", out_valid, 1'b0);
        load_part(21, 4, NE - 4);
        chk("ign_a_full", a_flat, mk_a(21));
        fire_done(mk_res(3));
        drain(mk_res(3), -1, mk_a(21));

        // Reset in the middle of a drain.
        load_part(31, 0, NE);
        fire_done(mk_res(10));
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
        end
        chk("pre_rst_data", out_data, 24'd50);
        chk("pre_rst_err", err_timeout, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_in_ready", in_ready, 1'b1);
        chk("mid_rst_err", err_timeout, 1'b0);
        chk("mid_rst_a_flat", a_flat, '0);
        chk("mid_rst_out_data", out_data, '0);
        for (int c = 0; c < 4; c++) begin
            chk("post_rst_start", start, 1'b0);
            chk("post_rst_valid", out_valid, 1'b0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ff_stream_host.md
FF_STREAM_HOST -- requirements
Module: ff_stream_host

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- N, 3, sentence length (matrix rows)
- D1, 3, model dimension (matrix columns)
- WIDTH, 8, input element width, signed
- OWIDTH, 24, result element width, signed
- TIMEOUT, 64, max cycles waiting for done
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input element valid
- in_ready  out  1  input element accepted when high with in_valid
- in_data  in  WIDTH  input element, row-major order
- a_flat  out  N*D1*WIDTH  assembled input matrix; element (i,j) at bits [(i*D1+j)*WIDTH +: WIDTH]
- start  out  1  one-cycle pulse launching the feed-forward engine
- done  in  1  engine completion strobe
- result_flat  in  N*D1*OWIDTH  engine result; element (i,j) at bits [(i*D1+j)*OWIDTH +: OWIDTH]
- out_valid  out  1  output element valid
- out_ready  in  1  downstream ready
- out_data  out  OWIDTH  output element, row-major order
- out_last  out  1  high with final element (index N*D1-1)
- busy  out  1  high in every state except LOAD
- err_timeout  out  1  sticky timeout flag

Function
REQ-003 SHALL implement FSM states LOAD, FIRE, WAIT, DRAIN, with a shared element index idx (0..N*D1-1).
REQ-004 LOAD: in_ready=1; each in_valid&&in_ready writes in_data into a_flat element idx and increments idx; the handshake at idx==N*D1-1 clears idx and moves to FIRE.
REQ-005 FIRE: in_ready=0; start=1 for exactly this one cycle; next state WAIT.
REQ-006 WAIT: in_ready=0; a wait counter increments each cycle; on done=1 the block captures result_flat into an internal N*D1 buffer, clears idx, and moves to DRAIN.
REQ-007 WAIT: if done has not been seen after TIMEOUT cycles, the block sets err_timeout=1, clears idx, and returns to LOAD without driving out_valid.
REQ-008 DRAIN: out_valid=1; out_data=buffer[idx]; out_last=(idx==N*D1-1); each out_valid&&out_ready increments idx; the transfer with out_last clears idx and moves to LOAD.
REQ-009 While out_ready=0 in DRAIN, out_data and out_last SHALL hold stable.
REQ-010 a_flat SHALL change only on LOAD handshakes; it holds stable through FIRE, WAIT and DRAIN.
REQ-011 done SHALL be ignored in LOAD, FIRE and DRAIN; the buffer changes only on capture in WAIT.
REQ-012 Results SHALL pass through unmodified (no clamping or sign handling), OWIDTH bits each.
REQ-013 out_valid SHALL be 0 outside DRAIN; in_ready SHALL be 0 outside LOAD.
REQ-014 Throughput: one element per cycle on each stream when unstalled; total latency = N*D1 load beats + 1 FIRE cycle + engine time + N*D1 drain beats.
REQ-015 err_timeout SHALL stay set until reset and SHALL NOT block further operation.

Reset
REQ-016 On reset=1 at a clk edge, regardless of state: state=LOAD, idx=0, wait counter=0, start=0, out_valid=0, out_last=0, out_data=0, err_timeout=0, busy=0, a_flat=0, and buffer=0.
REQ-017 Reset mid-operation SHALL abandon any partial load or drain; no start pulse or output beat follows.

Verification
REQ-018 Bench (N=D1=3, WIDTH=8, OWIDTH=24, TIMEOUT=16) SHALL cover the following scenarios:
- Load 1..9 back-to-back -> start high exactly one cycle, on the cycle after the 9th handshake; element (1,2) of a_flat = 6; in_ready=0 from that cycle.
- done with result elements 10,20,..,90 and out_ready=1 -> nine beats 10..90 on consecutive cycles; out_last only on 90; in_ready=1 on the next cycle.
- out_ready low for 3 cycles while out_data=40 -> out_data stays 40 and out_valid stays 1; the stream resumes with 50.
- No done after start -> err_timeout=1 after 16 WAIT cycles; state returns to LOAD with no out_valid; a new load of 9 elements works normally.
- done pulsed during LOAD after 4 elements -> ignored; idx continues from 4; no drain occurs.
- reset during DRAIN at element 5 -> next cycle out_valid=0, in_ready=1, err_timeout=0, and a_flat=0.
